machine_action_sched: RTL and testbench

Sequences memory actions emitted by the machine step logic onto a single memory request port and returns read data to the machine. It sits between the step function's 95-bit action output and the memory. It buffers up to QDEPTH actions in order, meters outstanding reads with a credit counter so that memory responses are never back-pressured, and provides a drain handshake for halting the machine cleanly.

---
 rtl/machine_action_sched_if.sv | 38 +++
 rtl/machine_action_sched.sv | 129 ++++++++++++
 tb/tb_machine_action_sched.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/machine_action_sched_if.sv
// Bus bundle for machine_action_sched: action input, memory request/response
// ports, read-result handshake and drain handshake.
interface machine_action_sched_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 63
);
  logic [ADDR_W+DATA_W+1:0] act;
  logic                     act_valid;
  logic                     act_ready;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_rsp_valid;
  logic [DATA_W-1:0]        mem_rsp_data;
  logic                     rd_valid;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_ready;
  logic                     drain_req;
  logic                     drained;

  // environment side: machine step logic plus memory
  modport master (
    output act, act_valid, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           rd_ready, drain_req,
    input  act_ready, mem_req_valid, mem_we, mem_addr, mem_wdata,
           rd_valid, rd_data, drained
  );

  // scheduler side
  modport slave (
    input  act, act_valid, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           rd_ready, drain_req,
    output act_ready, mem_req_valid, mem_we, mem_addr, mem_wdata,
           rd_valid, rd_data, drained
  );
endinterface

// File: rtl/machine_action_sched.sv
// In-order memory action scheduler: action queue, read credit metering,
// response buffer and drain handshake.
module machine_action_sched #(
  parameter int QDEPTH = 4,
  parameter int MAX_RD = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 63
) (
  input logic                   system1000,
  input logic                   system1000_rstn,
  machine_action_sched_if.slave bus
);
  localparam int QIW = $clog2(QDEPTH);
  localparam int QPW = QIW + 1;
  localparam int CW  = $clog2(MAX_RD + 1);
  localparam int RIW = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} st_t;

  st_t               st, st_nxt;
  entry_t            q [QDEPTH];
  logic [QPW-1:0]    q_hd, q_tl;
  logic [DATA_W-1:0] rf [MAX_RD];
  logic [RIW-1:0]    r_hd, r_tl;
  logic [CW-1:0]     rd_out, rsp_cnt;

  logic   q_empty, q_full, act_rdy, is_rd, is_wr, q_push, q_pop;
  logic   credit_ok, issue_ok, rd_iss, rsp_push, rsp_pop;
  entry_t hd_ent, new_ent;

  function automatic logic [RIW-1:0] r_inc(input logic [RIW-1:0] p);
    return (p == RIW'(MAX_RD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign q_empty   = (q_hd == q_tl);
  assign q_full    = (q_hd[QIW-1:0] == q_tl[QIW-1:0]) && (q_hd[QIW] != q_tl[QIW]);
  assign act_rdy   = !q_full && (st == RUN);
  assign is_rd     = (bus.act[ADDR_W+DATA_W+1 -: 2] == 2'b00);
  assign is_wr     = (bus.act[ADDR_W+DATA_W+1 -: 2] == 2'b01);
  assign q_push    = act_rdy && bus.act_valid && (is_rd || is_wr);
  assign hd_ent    = q[q_hd[QIW-1:0]];
  // reads in flight plus buffered responses must fit the response FIFO
  assign credit_ok = ({1'b0, rd_out} + {1'b0, rsp_cnt}) < (CW+1)'(MAX_RD);
  assign issue_ok  = !q_empty && (hd_ent.we || credit_ok);
  assign q_pop     = issue_ok && bus.mem_req_ready;
  assign rd_iss    = q_pop && !hd_ent.we;
  // a response with nothing outstanding is a stray and is dropped
  assign rsp_push  = bus.mem_rsp_valid && (rd_out != '0);
  assign rsp_pop   = (rsp_cnt != '0) && bus.rd_ready;

  // read enqueues zero data; write carries x
  always_comb begin
    new_ent      = '0;
    new_ent.we   = is_wr;
    new_ent.addr = bus.act[ADDR_W+DATA_W-1 -: ADDR_W];
    new_ent.data = is_wr ? bus.act[DATA_W-1:0] : '0;
  end

  // queue and response storage; contents are don't-care until pointed at
  always_ff @(posedge system1000) begin
    if (q_push)   q[q_tl[QIW-1:0]] <= new_ent;
    if (rsp_push) rf[r_tl]         <= bus.mem_rsp_data;
  end

  // pointers and counters
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      q_hd    <= '0;
      q_tl    <= '0;
      r_hd    <= '0;
      r_tl    <= '0;
      rd_out  <= '0;
      rsp_cnt <= '0;
    end else begin
      if (q_push)   q_tl <= q_tl + 1'b1;
      if (q_pop)    q_hd <= q_hd + 1'b1;
      if (rsp_push) r_tl <= r_inc(r_tl);
      if (rsp_pop)  r_hd <= r_inc(r_hd);
      case ({rd_iss, rsp_push})
        2'b10:   rd_out <= rd_out + 1'b1;
        2'b01:   rd_out <= rd_out - 1'b1;
        default: ;
      endcase
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + 1'b1;
        2'b01:   rsp_cnt <= rsp_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // drain FSM state register
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) st <= RUN;
    else                  st <= st_nxt;
  end

  // drain FSM next state
  always_comb begin
    st_nxt = st;
    case (st)
      RUN:   if (bus.drain_req) st_nxt = DRAIN;
      DRAIN: begin
        if (!bus.drain_req)                                       st_nxt = RUN;
        else if (q_empty && (rd_out == '0) && (rsp_cnt == '0)) st_nxt = IDLE;
      end
      IDLE:  if (!bus.drain_req) st_nxt = RUN;
      default: st_nxt = RUN;
    endcase
  end

  // outputs: request fields come from the stored head entry, zero when empty
  always_comb begin
    bus.act_ready     = act_rdy;
    bus.mem_req_valid = issue_ok;
    bus.mem_we        = q_empty ? 1'b0 : hd_ent.we;
    bus.mem_addr      = q_empty ? '0 : hd_ent.addr;
    bus.mem_wdata     = q_empty ? '0 : hd_ent.data;
    bus.rd_valid      = (rsp_cnt != '0);
    bus.rd_data       = (rsp_cnt != '0) ? rf[r_hd] : '0;
    bus.drained       = (st == IDLE);
  end
endmodule

// File: tb/tb_machine_action_sched.sv
// Directed bench for machine_action_sched.
module tb_machine_action_sched;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  machine_action_sched_if #(.ADDR_W(30), .DATA_W(63)) bus ();

  machine_action_sched #(.QDEPTH(4), .MAX_RD(4), .ADDR_W(30), .DATA_W(63)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .bus             (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [94:0] mk_rd(input logic [29:0] p);
    return {2'b00, p, 63'd0};
  endfunction

  function automatic logic [94:0] mk_wr(input logic [29:0] p, input logic [62:0] x);
    return {2'b01, p, x};
  endfunction

  function automatic logic [94:0] mk_nop(input logic t);
    return {1'b1, t, 93'd0};
  endfunction

  task automatic idle_inputs();
    bus.act = '0;  bus.act_valid = 0;  bus.mem_req_ready = 0;
    bus.mem_rsp_valid = 0;  bus.mem_rsp_data = '0;
    bus.rd_ready = 0;  bus.drain_req = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    step();
    step();
    rstn = 1;
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ardy"},  bus.act_ready, 1);
    chk({tag, "_mreqv"}, bus.mem_req_valid, 0);
    chk({tag, "_mwe"},   bus.mem_we, 0);
    chk({tag, "_maddr"}, bus.mem_addr, 0);
    chk({tag, "_mwd"},   bus.mem_wdata, 0);
    chk({tag, "_rdv"},   bus.rd_valid, 0);
    chk({tag, "_rdd"},   bus.rd_data, 0);
    chk({tag, "_drnd"},  bus.drained, 0);
  endtask

  initial begin
    int acc, sent, issued, prev_iss, rsp_idx, stalls, reqs, nonwe;
    logic flag, iss;

    // reset values
    idle_inputs();
    #2;
    chk_reset_vals("rst");
    do_reset();
    chk_reset_vals("rst_rel");

    // write then read same address, response after 3 cycles
    bus.mem_req_ready = 1;
    bus.act = mk_wr(30'h10, 63'h5A);  bus.act_valid = 1;
    step();
    bus.act = mk_rd(30'h10);
    chk("wr_v",    bus.mem_req_valid, 1);
    chk("wr_we",   bus.mem_we, 1);
    chk("wr_addr", bus.mem_addr, 30'h10);
    chk("wr_data", bus.mem_wdata, 63'h5A);
    step();
    bus.act_valid = 0;
    chk("rd_v",    bus.mem_req_valid, 1);
    chk("rd_we",   bus.mem_we, 0);
    chk("rd_addr", bus.mem_addr, 30'h10);
    chk("rd_wd",   bus.mem_wdata, 0);
    step();
    chk("rd_idle", bus.mem_req_valid, 0);
    step();
    step();
    bus.mem_rsp_valid = 1;  bus.mem_rsp_data = 63'h5A;
    step();
    bus.mem_rsp_valid = 0;
    chk("wr_rd_v", bus.rd_valid, 1);
    chk("wr_rd_d", bus.rd_data, 63'h5A);
    bus.rd_ready = 1;
    step();
    bus.rd_ready = 0;
    chk("wr_rd_pop", bus.rd_valid, 0);

    // queue full: 5+ reads offered with memory stalled
    do_reset();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.act = mk_rd(30'h20 + 30'(acc));  bus.act_valid = 1;
      flag = bus.act_ready;
      step();
      if (flag) acc++;
    end
    bus.act_valid = 0;
    chk("qf_acc",  acc, 4);
    chk("qf_ardy", bus.act_ready, 0);
    bus.mem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("qf_iv", bus.mem_req_valid, 1);
      chk("qf_ia", bus.mem_addr, 30'h20 + 30'(i));
      step();
    end
    bus.mem_req_ready = 0;
    chk("qf_empty", bus.mem_req_valid, 0);
    chk("qf_ardy2", bus.act_ready, 1);
    for (int i = 0; i < 4; i++) begin
      bus.mem_rsp_valid = 1;  bus.mem_rsp_data = 63'(100 + i);
      step();
    end
    bus.mem_rsp_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("qf_rv", bus.rd_valid, 1);
      chk("qf_rd", bus.rd_data, 63'(100 + i));
      bus.rd_ready = 1;
      step();
      bus.rd_ready = 0;
    end
    chk("qf_rdone", bus.rd_valid, 0);

    // credit limit: latency-1 memory, results not consumed
    do_reset();
    bus.mem_req_ready = 1;
    sent = 0;  issued = 0;  prev_iss = 0;  rsp_idx = 0;
    for (int c = 0; c < 20; c++) begin
      bus.act_valid = (sent < 6);
      bus.act = mk_rd(30'h40 + 30'(sent));
      bus.mem_rsp_valid = prev_iss[0];
      bus.mem_rsp_data = 63'h200 + 63'(rsp_idx);
      if (prev_iss != 0) rsp_idx++;
      flag = bus.act_valid && bus.act_ready;
      iss = bus.mem_req_valid && !bus.mem_we;
      step();
      if (flag) sent++;
      if (iss) issued++;
      prev_iss = iss ? 1 : 0;
    end
    bus.act_valid = 0;  bus.mem_rsp_valid = 0;
    chk("cr_sent",  sent, 6);
    chk("cr_iss",   issued, 4);
    chk("cr_block", bus.mem_req_valid, 0);
    chk("cr_rv",    bus.rd_valid, 1);
    chk("cr_rd0",   bus.rd_data, 63'h200);
    bus.rd_ready = 1;
    step();
    bus.rd_ready = 0;
    chk("cr_5v", bus.mem_req_valid, 1);
    chk("cr_5a", bus.mem_addr, 30'h44);
    chk("cr_rd1", bus.rd_data, 63'h201);

    // none actions interleaved with writes
    do_reset();
    bus.mem_req_ready = 1;
    stalls = 0;  reqs = 0;  nonwe = 0;
    for (int i = 0; i < 11; i++) begin
      bus.act_valid = (i < 8);
      bus.act = (i % 2 == 0) ? mk_nop(i[1]) : mk_wr(30'h60 + 30'(i / 2), 63'h70 + 63'(i));
      if (bus.act_valid && !bus.act_ready) stalls++;
      if (bus.mem_req_valid) begin
        chk("nf_addr", bus.mem_addr, 30'h60 + 30'(reqs));
        if (!bus.mem_we) nonwe++;
        reqs++;
      end
      step();
    end
    bus.act_valid = 0;
    chk("nf_reqs",  reqs, 4);
    chk("nf_nonwe", nonwe, 0);
    chk("nf_stall", stalls, 0);

    // drain with two reads queued
    do_reset();
    bus.act_valid = 1;
    bus.act = mk_rd(30'h80);  step();
    bus.act = mk_rd(30'h81);  step();
    bus.act_valid = 0;
    bus.drain_req = 1;
    step();
    chk("dr_ardy", bus.act_ready, 0);
    chk("dr_d0",   bus.drained, 0);
    bus.mem_req_ready = 1;
    step();
    step();
    bus.mem_req_ready = 0;
    chk("dr_qe", bus.mem_req_valid, 0);
    for (int i = 0; i < 2; i++) begin
      bus.mem_rsp_valid = 1;  bus.mem_rsp_data = 63'h300 + 63'(i);
      step();
    end
    bus.mem_rsp_valid = 0;
    chk("dr_d1", bus.drained, 0);
    for (int i = 0; i < 2; i++) begin
      chk("dr_rd", bus.rd_data, 63'h300 + 63'(i));
      bus.rd_ready = 1;
      step();
      bus.rd_ready = 0;
    end
    chk("dr_d2", bus.drained, 0);
    step();
    chk("dr_d3",    bus.drained, 1);
    chk("dr_ardy2", bus.act_ready, 0);
    bus.drain_req = 0;
    step();
    chk("dr_ardy3", bus.act_ready, 1);
    chk("dr_d4",    bus.drained, 0);

    // reset mid-operation
    do_reset();
    bus.act_valid = 1;
    bus.act = mk_rd(30'h90);  step();
    bus.mem_req_ready = 1;
    bus.act = mk_wr(30'h91, 63'h1);  step();
    bus.mem_req_ready = 0;
    bus.act = mk_rd(30'h92);  step();
    bus.act = mk_wr(30'h93, 63'h2);  step();
    bus.act_valid = 0;
    chk("mr_pre_v", bus.mem_req_valid, 1);
    chk("mr_pre_a", bus.mem_addr, 30'h91);
    rstn = 0;
    #1;
    chk_reset_vals("mr");
    step();
    rstn = 1;
    bus.mem_rsp_valid = 1;  bus.mem_rsp_data = 63'h777;
    step();
    bus.mem_rsp_valid = 0;
    chk("mr_late_v", bus.rd_valid, 0);
    step();
    chk("mr_late_v2", bus.rd_valid, 0);
    chk("mr_mreqv",   bus.mem_req_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
